// File: rtl/iobus_uart_tx.sv
// rtl/iobus_uart_tx.sv - IOBUS-mapped 8N1 UART transmitter with byte FIFO
// Frames run back to back while the FIFO holds data; status register reports COUNT/OVERRUN/FULL/EMPTY/BUSY.
module iobus_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] DATA_AD      = 32'h1110_0000,
  parameter logic [31:0] STAT_AD      = 32'h1110_0004
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        TX_DONE
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push_req, stat_wr, fifo_full, fifo_empty, baud_last;
  logic pop, push, drop;
  logic unused_wdata;

  assign unused_wdata = ^IOBUS_OUT[31:8];
  assign push_req     = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
  assign stat_wr      = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
  assign fifo_full    = (count_q == COUNT_FULL);
  assign fifo_empty   = (count_q == '0);
  assign baud_last    = (baud_q == BAUD_LAST);

  assign TX      = tx_q;
  assign TX_DONE = (state_q == S_STOP) && baud_last;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = S_START;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A full FIFO still accepts a byte when the transmitter pops on the same edge.
  always_comb begin
    push      = push_req && (!fifo_full || pop);
    drop      = push_req && fifo_full && !pop;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    overrun_d = overrun_q;
    if (drop)         overrun_d = 1'b1;
    else if (stat_wr) overrun_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
  end

  always_comb begin
    RD_DATA = '0;
    if (IOBUS_ADDR == STAT_AD)
      RD_DATA[CW+3:0] = {count_q, overrun_q, fifo_full, fifo_empty, state_q != S_IDLE};
  end

endmodule
